// File: rtl/spi_block_writer.sv
// spi_block_writer: buffers one host block and sends it as an SD SPI single-block write packet; define SPI_WRITER_CRC_EN to build the CRC16 generator
module spi_block_writer #(
    parameter int BLOCK_SIZE = 512,
    parameter int ADDR_W     = 10,
    parameter int MAX_RESP   = 8,
    parameter int MAX_BUSY   = 32767
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_w,
    input  logic       write_en,
    input  logic [7:0] write_data,
    output logic       write_full,
    input  logic       program_start,
    output logic       prog_busy,
    output logic       prog_done,
    output logic [1:0] prog_status,
    output logic       ostart,
    output logic [7:0] otx,
    input  logic       ordy,
    input  logic [7:0] odata
);
    localparam int AW = $clog2(BLOCK_SIZE);

    typedef enum logic [3:0] {IDLE, GAP, TOKEN, FETCH, DATA, CRC_H, CRC_L, RESP, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [7:0] mem [BLOCK_SIZE];
    logic [7:0] rdata, tx_byte, data_byte, crc_hi, crc_lo;
    logic [ADDR_W-1:0] wptr, idx;
    logic [15:0] cnt;
    logic [1:0] status, st_val;
    logic pend, xfer, send, fin, st_set, cnt_clr, cnt_inc, idx_inc, start, wr;

    assign start       = state == IDLE && program_start;
    assign wr          = state == IDLE && !init_w && write_en && !write_full;
    assign write_full  = wptr == ADDR_W'(BLOCK_SIZE);
    assign prog_busy   = state != IDLE;
    assign prog_done   = state == DONE;
    assign prog_status = status;
    assign xfer        = state inside {GAP, TOKEN, DATA, CRC_H, CRC_L, RESP, BUSY};
    assign send        = xfer && !pend;
    assign fin         = pend && ordy;
    assign data_byte   = idx < wptr ? rdata : 8'h00;

`ifdef SPI_WRITER_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
        return r;
    endfunction

    // CRC restarts with each packet and absorbs every data byte as it is issued
    always_ff @(posedge clk)
        if (rst || start) crc <= 16'h0000;
        else if (state == DATA && send) crc <= crc16(crc, data_byte);

    assign crc_hi = crc[15:8];
    assign crc_lo = crc[7:0];
`else
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    // block buffer: host writes at wptr, packet side reads idx with one cycle latency
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= write_data;
        rdata <= mem[idx[AW-1:0]];
    end

    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_n;

    // next state, byte to send and response decoding
    always_comb begin
        state_n = state;
        tx_byte = 8'hFF;
        st_set  = 1'b0;
        st_val  = 2'b00;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        idx_inc = 1'b0;
        case (state)
            IDLE:  if (program_start) state_n = GAP;
            GAP:   if (fin) state_n = TOKEN;
            TOKEN: begin
                tx_byte = 8'hFE;
                if (fin) state_n = FETCH;
            end
            FETCH: state_n = DATA;
            DATA: begin
                tx_byte = data_byte;
                if (fin) begin
                    idx_inc = 1'b1;
                    state_n = idx == ADDR_W'(BLOCK_SIZE - 1) ? CRC_H : FETCH;
                end
            end
            CRC_H: begin
                tx_byte = crc_hi;
                if (fin) state_n = CRC_L;
            end
            CRC_L: begin
                tx_byte = crc_lo;
                if (fin) begin
                    cnt_clr = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: if (fin) begin
                if ((odata & 8'h11) == 8'h01) begin
                    if ((odata & 8'h1F) == 8'h05) begin
                        cnt_clr = 1'b1;
                        state_n = BUSY;
                    end else begin
                        st_set  = 1'b1;
                        st_val  = (odata & 8'h1F) == 8'h0B ? 2'b01 : 2'b10;
                        state_n = DONE;
                    end
                end else if (cnt == 16'(MAX_RESP - 1)) begin
                    st_set  = 1'b1;
                    st_val  = 2'b11;
                    state_n = DONE;
                end else cnt_inc = 1'b1;
            end
            BUSY: if (fin) begin
                if (odata != 8'h00 || cnt == 16'(MAX_BUSY - 1)) begin
                    st_set  = 1'b1;
                    st_val  = odata != 8'h00 ? 2'b00 : 2'b11;
                    state_n = DONE;
                end else cnt_inc = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // transfer handshake, pointers, poll counter and status
    always_ff @(posedge clk)
        if (rst) begin
            pend   <= 1'b0;
            ostart <= 1'b0;
            otx    <= 8'hFF;
            idx    <= '0;
            wptr   <= '0;
            cnt    <= '0;
            status <= 2'b00;
        end else begin
            ostart <= send;
            if (send) begin
                otx  <= tx_byte;
                pend <= 1'b1;
            end else if (fin) pend <= 1'b0;
            if (start) idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (state == DONE || (state == IDLE && init_w)) wptr <= '0;
            else if (wr) wptr <= wptr + 1'b1;
            if (cnt_clr) cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 16'd1;
            if (st_set) status <= st_val;
        end
endmodule

// File: tb/tb_spi_block_writer.sv
// tb_spi_block_writer: vector-driven bench for spi_block_writer with a one-cycle SPI engine model; honours SPI_WRITER_CRC_EN
module tb_spi_block_writer;
    localparam int BS = 512;
    localparam int MR = 8;
    localparam int MB = 40;

    logic clk = 1'b0, rst = 1'b1, init_w = 1'b0, write_en = 1'b0, program_start = 1'b0, ordy = 1'b0;
    logic [7:0] write_data = 8'h00, odata = 8'hFF;
    logic write_full, prog_busy, prog_done, ostart;
    logic [1:0] prog_status;
    logic [7:0] otx;

    int checks = 0, errors = 0;
    logic [7:0] txlog [0:16383];
    int txn = 0, base = 0, rlen_g = 0;
    logic [0:4][7:0] rsp = '0;
    logic [7:0] dflt_g = 8'hFF;

    typedef struct {
        int nwr;
        int mode;
        logic [0:4][7:0] r;
        int rlen;
        logic [7:0] dflt;
        logic [1:0] st;
        int polls;
        string tag;
    } vec_t;
    vec_t v [7];

    spi_block_writer #(.BLOCK_SIZE(BS), .ADDR_W(10), .MAX_RESP(MR), .MAX_BUSY(MB)) dut (
        .clk(clk), .rst(rst), .init_w(init_w), .write_en(write_en), .write_data(write_data),
        .write_full(write_full), .program_start(program_start), .prog_busy(prog_busy),
        .prog_done(prog_done), .prog_status(prog_status), .ostart(ostart), .otx(otx),
        .ordy(ordy), .odata(odata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] resp_at(int k);
        return k < 0 ? 8'hFF : k < rlen_g ? rsp[k] : dflt_g;
    endfunction

    // engine model: answers each ostart with ordy one cycle later and logs the byte sent
    always @(negedge clk) begin
        ordy = 1'b0;
        if (ostart) begin
            if (txn < 16384) txlog[txn] = otx;
            odata = resp_at(txn - base - (BS + 4));
            ordy = 1'b1;
            txn++;
        end
    end

    function automatic logic [7:0] pat(int i, int mode);
        logic [7:0] b;
        b = 8'(i);
        return mode == 0 ? 8'hFF : mode == 1 ? 8'((i + 1) * 17) : (i == 512 ? 8'hEE : b ^ 8'h5A);
    endfunction

    function automatic logic [7:0] exp_data(int i, int nwr, int mode);
        return i < nwr ? pat(i, mode) : 8'h00;
    endfunction

    function automatic logic [15:0] crc_model(int nwr, int mode);
        logic [15:0] c;
        logic [7:0] d;
        logic fb;
        c = 16'h0000;
        for (int i = 0; i < BS; i++) begin
            d = exp_data(i, nwr, mode);
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ d[b];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t);
        logic seen;
        logic [1:0] st;
        logic [15:0] c;
        int n, bad;
        init_w = 1'b1;
        tick();
        init_w = 1'b0;
        for (int i = 0; i < t.nwr; i++) begin
            write_en = 1'b1;
            write_data = pat(i, t.mode);
            tick();
        end
        write_en = 1'b0;
        chk({t.tag, "_full_before"}, write_full, t.nwr >= BS);
        rsp = t.r;
        rlen_g = t.rlen;
        dflt_g = t.dflt;
        base = txn;
        program_start = 1'b1;
        tick();
        program_start = 1'b0;
        chk({t.tag, "_busy"}, prog_busy, 1);
        repeat (10) tick();
        init_w = 1'b1;
        write_en = 1'b1;
        write_data = 8'hC3;
        program_start = 1'b1;
        tick();
        init_w = 1'b0;
        write_en = 1'b0;
        program_start = 1'b0;
        seen = 1'b0;
        st = 2'b00;
        for (int k = 0; k < 4000 && !seen; k++) begin
            tick();
            if (prog_done) begin
                seen = 1'b1;
                st = prog_status;
            end
        end
        chk({t.tag, "_done_seen"}, seen, 1);
        chk({t.tag, "_status"}, st, t.st);
        tick();
        chk({t.tag, "_done_pulse"}, prog_done, 0);
        chk({t.tag, "_idle"}, prog_busy, 0);
        chk({t.tag, "_full_after"}, write_full, 0);
        n = txn - base;
        chk({t.tag, "_xfers"}, n, BS + 4 + t.polls);
        chk({t.tag, "_gap"}, txlog[base], 8'hFF);
        chk({t.tag, "_token"}, txlog[base + 1], 8'hFE);
        bad = 0;
        for (int i = 0; i < BS; i++)
            if (txlog[base + 2 + i] !== exp_data(i, t.nwr < BS ? t.nwr : BS, t.mode)) bad++;
        chk({t.tag, "_data_bad"}, bad, 0);
`ifdef SPI_WRITER_CRC_EN
        c = crc_model(t.nwr < BS ? t.nwr : BS, t.mode);
`else
        c = 16'hFFFF;
`endif
        chk({t.tag, "_crc"}, {txlog[base + BS + 2], txlog[base + BS + 3]}, c);
        bad = 0;
        for (int k = 0; k < t.polls && base + BS + 4 + k < 16384; k++)
            if (txlog[base + BS + 4 + k] !== 8'hFF) bad++;
        chk({t.tag, "_polls_ff"}, bad, 0);
    endtask

    initial begin
        int dn;
        v[0] = '{512, 0, {8'hE5, 8'h00, 8'h00, 8'h00, 8'hFF}, 5, 8'hFF, 2'b00, 5, "allff"};
        v[1] = '{3, 1, {8'hE5, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 2, 8'hFF, 2'b00, 2, "short"};
        v[2] = '{512, 1, {8'hEB, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1, 8'hFF, 2'b01, 1, "crcrej"};
        v[3] = '{0, 0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 8'hFF, 2'b11, MR, "resp_to"};
        v[4] = '{100, 1, {8'hFF, 8'h0D, 8'hFF, 8'hFF, 8'hFF}, 2, 8'hFF, 2'b10, 2, "badtok"};
        v[5] = '{512, 0, {8'hE5, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h00, 2'b11, 1 + MB, "busy_to"};
        v[6] = '{2, 1, {8'hFF, 8'hFF, 8'hE5, 8'h00, 8'h07}, 5, 8'hFF, 2'b00, 5, "restart"};
        repeat (3) tick();
        chk("rst_busy", prog_busy, 0);
        chk("rst_done", prog_done, 0);
        chk("rst_status", prog_status, 0);
        chk("rst_ostart", ostart, 0);
        chk("rst_otx", otx, 8'hFF);
        chk("rst_full", write_full, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) run(v[i]);
`ifdef SPI_WRITER_CRC_EN
        chk("crc_allff_const", crc_model(BS, 0), 16'h7FA1);
`endif
        for (int i = 0; i < BS; i++) begin
            write_en = 1'b1;
            write_data = 8'hFF;
            tick();
        end
        write_en = 1'b0;
        base = txn;
        program_start = 1'b1;
        tick();
        program_start = 1'b0;
        for (int k = 0; k < 2000 && txn - base < 102; k++) tick();
        chk("mid_reached", txn - base >= 102, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", prog_busy, 0);
        chk("mid_rst_ostart", ostart, 0);
        chk("mid_rst_full", write_full, 0);
        chk("mid_rst_status", prog_status, 0);
        dn = 0;
        repeat (20) begin
            tick();
            if (prog_done) dn++;
        end
        chk("mid_rst_no_done", dn, 0);
        run('{513, 2, {8'hE5, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 2, 8'hFF, 2'b00, 2, "ovf"});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
